bus_port_fifo: RTL and testbench

BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

---
 rtl/bus_port_fifo.sv | 102 ++++++++++
 tb/tb_bus_port_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_port_fifo.sv
// Bus port with two independent circular FIFOs: TX (device -> bus arbiter) and
// RX (bus -> device), each show-ahead with occupancy counts and sticky error flags.
module bus_port_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dev_wr,
  input  logic [pckg_sz-1:0]         dev_wr_data,
  output logic                       tx_full,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic                       rx_valid,
  output logic [pckg_sz-1:0]         rx_data,
  input  logic                       dev_rd,
  output logic                       rx_full,
  output logic [$clog2(depth+1)-1:0] tx_count,
  output logic [$clog2(depth+1)-1:0] rx_count,
  output logic                       tx_ovf,
  output logic                       rx_ovf,
  output logic                       tx_udf
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth+1);
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [aw-1:0]      tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;

  logic tx_pop_ok, tx_wr_ok, rx_rd_ok, rx_wr_ok;

  // A write into a full FIFO is still accepted when the head leaves in the same cycle
  assign tx_pop_ok = pop && (tx_count != '0);
  assign tx_wr_ok  = dev_wr && ((tx_count != full_cnt) || tx_pop_ok);
  assign rx_rd_ok  = dev_rd && (rx_count != '0);
  assign rx_wr_ok  = push && ((rx_count != full_cnt) || rx_rd_ok);

  assign pndng    = (tx_count != '0);
  assign rx_valid = (rx_count != '0);
  assign tx_full  = (tx_count == full_cnt);
  assign rx_full  = (rx_count == full_cnt);
  assign D_pop    = pndng ? tx_mem[tx_rd_ptr] : '0;
  assign rx_data  = rx_valid ? rx_mem[rx_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      tx_ovf    <= 1'b0;
      tx_udf    <= 1'b0;
    end else begin
      if (tx_wr_ok)
        tx_wr_ptr <= tx_wr_ptr + aw'(1);
      if (tx_pop_ok)
        tx_rd_ptr <= tx_rd_ptr + aw'(1);
      if (tx_wr_ok && !tx_pop_ok)
        tx_count <= tx_count + cw'(1);
      else if (!tx_wr_ok && tx_pop_ok)
        tx_count <= tx_count - cw'(1);
      if (dev_wr && !tx_wr_ok)
        tx_ovf <= 1'b1;
      if (pop && (tx_count == '0))
        tx_udf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      rx_ovf    <= 1'b0;
    end else begin
      if (rx_wr_ok)
        rx_wr_ptr <= rx_wr_ptr + aw'(1);
      if (rx_rd_ok)
        rx_rd_ptr <= rx_rd_ptr + aw'(1);
      if (rx_wr_ok && !rx_rd_ok)
        rx_count <= rx_count + cw'(1);
      else if (!rx_wr_ok && rx_rd_ok)
        rx_count <= rx_count - cw'(1);
      if (push && !rx_wr_ok)
        rx_ovf <= 1'b1;
    end
  end

  // Storage is never reset; the pointers and counts alone define what is valid
  always_ff @(posedge clk) begin
    if (tx_wr_ok)
      tx_mem[tx_wr_ptr] <= dev_wr_data;
    if (rx_wr_ok)
      rx_mem[rx_wr_ptr] <= D_push;
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Self-checking bench for bus_port_fifo: a queue scoreboard per FIFO plus a vector
// table for the basic sequences and hand-written sequences for full/wrap/reset cases.
module tb_bus_port_fifo;

  localparam int PW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dev_wr = 1'b0;
  logic [PW-1:0] dev_wr_data = '0;
  logic          tx_full, pndng;
  logic [PW-1:0] D_pop;
  logic          pop = 1'b0;
  logic          push = 1'b0;
  logic [PW-1:0] D_push = '0;
  logic          rx_valid;
  logic [PW-1:0] rx_data;
  logic          dev_rd = 1'b0;
  logic          rx_full;
  logic [3:0]    tx_count, rx_count;
  logic          tx_ovf, rx_ovf, tx_udf;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] txq[$];
  logic [PW-1:0] rxq[$];
  logic          mTxOvf = 1'b0, mRxOvf = 1'b0, mTxUdf = 1'b0;

  typedef struct {
    logic          rst;
    logic          wr;
    logic [PW-1:0] wdata;
    logic          pp;
    logic          ps;
    logic [PW-1:0] pdata;
    logic          rd;
    int            txc;
    logic [PW-1:0] dpop;
    int            rxc;
    logic [PW-1:0] rdata;
    logic [2:0]    flags;
  } vec_t;

  vec_t vecs[10];

  bus_port_fifo #(.pckg_sz(PW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .dev_wr(dev_wr), .dev_wr_data(dev_wr_data),
    .tx_full(tx_full), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .rx_valid(rx_valid), .rx_data(rx_data),
    .dev_rd(dev_rd), .rx_full(rx_full), .tx_count(tx_count), .rx_count(rx_count),
    .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .tx_udf(tx_udf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("pndng",    32'(pndng),    32'(txq.size() != 0));
    checkOutput("D_pop",    32'(D_pop),    (txq.size() != 0) ? 32'(txq[0]) : 32'h0);
    checkOutput("tx_count", 32'(tx_count), 32'(txq.size()));
    checkOutput("tx_full",  32'(tx_full),  32'(txq.size() == DEPTH));
    checkOutput("rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
    checkOutput("rx_data",  32'(rx_data),  (rxq.size() != 0) ? 32'(rxq[0]) : 32'h0);
    checkOutput("rx_count", 32'(rx_count), 32'(rxq.size()));
    checkOutput("rx_full",  32'(rx_full),  32'(rxq.size() == DEPTH));
    checkOutput("flags",    32'({tx_ovf, rx_ovf, tx_udf}), 32'({mTxOvf, mRxOvf, mTxUdf}));
  endtask

  // Drive one cycle, update the scoreboard from pre-edge state, then check after the edge
  task automatic applyStimulus(input logic r, input logic w, input logic [PW-1:0] wd,
                               input logic p, input logic ps, input logic [PW-1:0] pd,
                               input logic rd);
    bit txPopOk, txWrOk, rxRdOk, rxWrOk;
    reset = r; dev_wr = w; dev_wr_data = wd; pop = p; push = ps; D_push = pd; dev_rd = rd;
    if (r) begin
      txq.delete(); rxq.delete();
      mTxOvf = 1'b0; mRxOvf = 1'b0; mTxUdf = 1'b0;
    end else begin
      txPopOk = p && (txq.size() != 0);
      txWrOk  = w && ((txq.size() < DEPTH) || txPopOk);
      rxRdOk  = rd && (rxq.size() != 0);
      rxWrOk  = ps && ((rxq.size() < DEPTH) || rxRdOk);
      if (p && txq.size() == 0) mTxUdf = 1'b1;
      if (w && !txWrOk) mTxOvf = 1'b1;
      if (ps && !rxWrOk) mRxOvf = 1'b1;
      if (txPopOk) checkOutput("sb_tx_pop", 32'(D_pop), 32'(txq.pop_front()));
      if (rxRdOk)  checkOutput("sb_rx_rd", 32'(rx_data), 32'(rxq.pop_front()));
      if (txWrOk) txq.push_back(wd);
      if (rxWrOk) rxq.push_back(pd);
    end
    @(posedge clk);
    #1;
    checkModel();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 0, 16'h0000, 3'b000};
    vecs[1] = '{1'b0, 1'b1, 16'h0201, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 16'h0201, 0, 16'h0000, 3'b000};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 16'h0000, 0, 16'h0000, 3'b000};
    vecs[3] = '{1'b0, 1'b1, 16'h0355, 1'b1, 1'b0, 16'h0000, 1'b0, 1, 16'h0355, 0, 16'h0000, 3'b001};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFAA, 1'b0, 1, 16'h0355, 1, 16'hFFAA, 3'b001};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0311, 1'b0, 1, 16'h0355, 2, 16'hFFAA, 3'b001};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0355, 1, 16'h0311, 3'b001};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0355, 0, 16'h0000, 3'b001};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 16'h0355, 0, 16'h0000, 3'b001};
    vecs[9] = '{1'b1, 1'b1, 16'h0444, 1'b0, 1'b1, 16'h0555, 1'b0, 0, 16'h0000, 0, 16'h0000, 3'b000};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].wdata, vecs[i].pp,
                    vecs[i].ps, vecs[i].pdata, vecs[i].rd);
      checkOutput($sformatf("vec%0d_tx_count", i), 32'(tx_count), 32'(vecs[i].txc));
      checkOutput($sformatf("vec%0d_D_pop", i), 32'(D_pop), 32'(vecs[i].dpop));
      checkOutput($sformatf("vec%0d_rx_count", i), 32'(rx_count), 32'(vecs[i].rxc));
      checkOutput($sformatf("vec%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].rdata));
      checkOutput($sformatf("vec%0d_flags", i), 32'({tx_ovf, rx_ovf, tx_udf}), 32'(vecs[i].flags));
    end

    // TX fill, overflow on a ninth write, then drain in order
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
    checkOutput("tx_full_after_8", 32'(tx_full), 32'h1);
    applyStimulus(1'b0, 1'b1, 16'h01FF, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("tx_ovf_after_9th", 32'(tx_ovf), 32'h1);
    checkOutput("tx_count_after_9th", 32'(tx_count), 32'h8);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("drain_D_pop%0d", i), 32'(D_pop), 32'h0100 + 32'(i));
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    end
    checkOutput("drain_empty_pndng", 32'(pndng), 32'h0);

    // Full FIFO with write and pop together, then pointer wrap with in-order data
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h02AA, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("full_wrpop_count", 32'(tx_count), 32'h8);
    checkOutput("full_wrpop_ovf", 32'(tx_ovf), 32'h0);
    for (int i = 0; i < DEPTH - 1; i++)
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("full_wrpop_last", 32'(D_pop), 32'h02AA);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b1, 16'($urandom), 1'b1, 1'b0, '0, 1'b0);
    checkOutput("wrap_count", 32'(tx_count), 32'h1);

    // RX fill, simultaneous push/read when full, then overflow without a read
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'hF000 + 16'(i), 1'b0);
    checkOutput("rx_full_after_8", 32'(rx_full), 32'h1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'hF0AA, 1'b1);
    checkOutput("rx_full_pushrd_ovf", 32'(rx_ovf), 32'h0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'hF0BB, 1'b0);
    checkOutput("rx_ovf_9th", 32'(rx_ovf), 32'h1);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Reset with pending traffic and set flags, then the first cycle after reset
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, 16'h0700 + 16'(i), 1'b0, (i < 3), 16'h0800 + 16'(i), 1'b0);
    checkOutput("pre_reset_tx_count", 32'(tx_count), 32'h5);
    checkOutput("pre_reset_rx_count", 32'(rx_count), 32'h3);
    applyStimulus(1'b1, 1'b1, 16'h0999, 1'b0, 1'b1, 16'h0AAA, 1'b0);
    checkOutput("reset_tx_count", 32'(tx_count), 32'h0);
    checkOutput("reset_rx_count", 32'(rx_count), 32'h0);
    checkOutput("reset_flags", 32'({tx_ovf, rx_ovf, tx_udf, pndng, rx_valid}), 32'h0);
    applyStimulus(1'b0, 1'b1, 16'h0B0B, 1'b0, 1'b1, 16'h0C0C, 1'b0);
    checkOutput("post_reset_D_pop", 32'(D_pop), 32'h0B0B);
    checkOutput("post_reset_rx_data", 32'(rx_data), 32'h0C0C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
